// File: rtl/xtl_clk_monitor.sv
// xtl_clk_monitor
//   Supervises a crystal oscillator clock against the always-running RC clock.
//   XTL rising edges are counted over fixed gate windows of CLK cycles. After a
//   start-up wait, a good window switches the fabric onto the crystal (RUN).
//   Bad windows during acquisition or in RUN fall back to the RC clock (FAIL).
// Ports
//   CLK          RC fabric clock, all logic on its rising edge
//   RESET        asynchronous, active-high
//   ENABLE       monitor enable; low returns to IDLE on the next edge
//   RETRY        one-cycle pulse that restarts acquisition from FAIL
//   XTL_CLK_IN   crystal clock under test (asynchronous to CLK)
//   CLK_SEL      0 = RC source, 1 = crystal (high only in RUN)
//   XTL_OK       high while in RUN
//   XTL_FAIL     high while in FAIL
//   FREQ_COUNT   edge count of the last completed window
//   COUNT_VALID  one-cycle pulse when FREQ_COUNT updates
//   STATE        IDLE=0 WARMUP=1 MEASURE=2 RUN=3 FAIL=4
module xtl_clk_monitor #(
  parameter int GATE_CYCLES   = 50000,
  parameter int EXP_COUNT     = 20000,
  parameter int TOL           = 200,
  parameter int WARMUP_CYCLES = 65535,
  parameter int MAX_RETRY     = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ENABLE,
  input  logic        RETRY,
  input  logic        XTL_CLK_IN,
  output logic        CLK_SEL,
  output logic        XTL_OK,
  output logic        XTL_FAIL,
  output logic [15:0] FREQ_COUNT,
  output logic        COUNT_VALID,
  output logic [2:0]  STATE
);
  localparam int GW = $clog2(GATE_CYCLES + 1);
  localparam int WW = $clog2(WARMUP_CYCLES + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int LO = (EXP_COUNT > TOL) ? EXP_COUNT - TOL : 0;
  localparam int HI = EXP_COUNT + TOL;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WARMUP  = 3'd1,
    S_MEASURE = 3'd2,
    S_RUN     = 3'd3,
    S_FAIL    = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic            xs1, xs2, xs3;
  logic [WW-1:0]   warm_cnt;
  logic [GW-1:0]   gate_cnt;
  logic [15:0]     edge_cnt;
  logic [RW-1:0]   retry_cnt;
  logic            bad_flag;

  logic            xtl_edge, measuring, win_end, win_good;
  logic [15:0]     win_cnt;

  assign xtl_edge  = xs2 & ~xs3;
  assign measuring = ENABLE && (state == S_MEASURE || state == S_RUN);
  assign win_end   = measuring && (gate_cnt == GW'(GATE_CYCLES - 1));
  // Count including this cycle's edge, so an edge on the last gate cycle
  // lands in the closing window. Saturates instead of wrapping.
  assign win_cnt   = (edge_cnt == 16'hFFFF) ? 16'hFFFF : edge_cnt + {15'd0, xtl_edge};
  assign win_good  = (int'(win_cnt) >= LO) && (int'(win_cnt) <= HI);
  assign STATE     = state;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (ENABLE) state_nxt = S_WARMUP;
      S_WARMUP:  if (warm_cnt == WW'(WARMUP_CYCLES - 1)) state_nxt = S_MEASURE;
      S_MEASURE: if (win_end) begin
                   if (win_good) state_nxt = S_RUN;
                   else if (int'(retry_cnt) + 1 >= MAX_RETRY) state_nxt = S_FAIL;
                 end
      S_RUN:     if (win_end && !win_good && bad_flag) state_nxt = S_FAIL;
      S_FAIL:    if (RETRY) state_nxt = S_WARMUP;
      default:   state_nxt = S_IDLE;
    endcase
    if (!ENABLE) state_nxt = S_IDLE;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= S_IDLE;
      {xs3, xs2, xs1} <= '0;
      warm_cnt    <= '0;
      gate_cnt    <= '0;
      edge_cnt    <= '0;
      retry_cnt   <= '0;
      bad_flag    <= 1'b0;
      FREQ_COUNT  <= '0;
      COUNT_VALID <= 1'b0;
      CLK_SEL     <= 1'b0;
      XTL_OK      <= 1'b0;
      XTL_FAIL    <= 1'b0;
    end else begin
      state       <= state_nxt;
      {xs3, xs2, xs1} <= {xs2, xs1, XTL_CLK_IN};

      // Held at zero outside WARMUP, so every WARMUP entry runs the full wait.
      warm_cnt <= (state == S_WARMUP && state_nxt == S_WARMUP) ? warm_cnt + 1'b1 : '0;

      // Gate/edge counters only run while measuring; any exit clears them,
      // which also gives MEASURE a clean start after WARMUP.
      if (measuring) begin
        gate_cnt <= win_end ? '0 : gate_cnt + 1'b1;
        edge_cnt <= win_end ? '0 : win_cnt;
      end else begin
        gate_cnt <= '0;
        edge_cnt <= '0;
      end

      if (state == S_MEASURE && win_end && !win_good) retry_cnt <= retry_cnt + 1'b1;
      else if (state != S_MEASURE)                    retry_cnt <= '0;

      if (state == S_RUN && win_end) bad_flag <= !win_good;
      else if (state != S_RUN)       bad_flag <= 1'b0;

      COUNT_VALID <= win_end;
      if (win_end) FREQ_COUNT <= win_cnt;

      // Driven from the next state so they change in the same cycle as STATE.
      CLK_SEL  <= (state_nxt == S_RUN);
      XTL_OK   <= (state_nxt == S_RUN);
      XTL_FAIL <= (state_nxt == S_FAIL);
    end
  end
endmodule
